// File: rtl/tt_spine_ctrl_if.sv
// tt_spine_ctrl_if: spine bundle between the spine head controller and the
// row muxes. The controller drives the inward bundle and listens on the
// outward bundle.
interface tt_spine_ctrl_if;
  logic [30:0] spine_iw;  // {gh, usr[17:0], sel[9:0], ena, gl}
  logic [25:0] spine_ow;  // {gh, usr[23:0], gl}

  modport master (output spine_iw, input spine_ow);
  modport slave  (input spine_iw, output spine_ow);
endinterface

// File: rtl/tt_spine_ctrl.sv
// tt_spine_ctrl: controller at the head of the vertical spine.
// Synchronises slow pad controls, steps a 10-bit design-select counter,
// sequences the selected user module through settle/reset/run while gating
// its clock and reset, and returns the module's outputs to the pads.
// Optional macro TT_SPINE_CTRL_OUT_REG_EN: when defined, the pad return path
// is registered (one clk lag); otherwise it is combinational from spine_ow.
module tt_spine_ctrl #(
  parameter int N_IO       = 8,
  parameter int N_O        = 8,
  parameter int N_I        = 10,
  parameter int SETTLE_CYC = 4,
  parameter int RST_CYC    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_sel_rst_n,
  input  logic            ctrl_sel_inc,
  input  logic            ctrl_ena,
  input  logic            pad_ui_clk,
  input  logic            pad_ui_rst_n,
  input  logic [N_I-3:0]  pad_ui_in,
  input  logic [N_IO-1:0] pad_uio_in,
  output logic [N_O-1:0]  pad_uo_out,
  output logic [N_IO-1:0] pad_uio_out,
  output logic [N_IO-1:0] pad_uio_oe,
  tt_spine_ctrl_if.master spine,
  output logic [9:0]      dbg_sel,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESET  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // Counter load values: a phase lasts (load + 1) cycles.
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] RST_LD    = 8'(RST_CYC - 1);

  logic [1:0]  r_sel_rst_sync;
  logic [1:0]  r_inc_sync;
  logic [1:0]  r_ena_sync;
  logic [1:0]  r_ui_rst_sync;
  logic        r_inc_prev;
  logic [9:0]  r_sel_cnt;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_clk_en;

  logic        w_sel_rst_n;
  logic        w_inc_edge;
  logic        w_ena;
  logic        w_ui_rst_n;
  logic        w_abort;
  logic        w_live;
  logic        w_run;
  logic        w_um_clk;
  logic        w_um_rst_n;
  logic [N_IO+N_I-1:0] w_usr;
  logic [23:0] w_ret;
  logic        w_unused_ow_guards;

  // Two-flop synchronisers for the asynchronous pad controls; all clear to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_rst_sync <= 2'b00;
      r_inc_sync     <= 2'b00;
      r_ena_sync     <= 2'b00;
      r_ui_rst_sync  <= 2'b00;
      r_inc_prev     <= 1'b0;
    end else begin
      r_sel_rst_sync <= {r_sel_rst_sync[0], ctrl_sel_rst_n};
      r_inc_sync     <= {r_inc_sync[0], ctrl_sel_inc};
      r_ena_sync     <= {r_ena_sync[0], ctrl_ena};
      r_ui_rst_sync  <= {r_ui_rst_sync[0], pad_ui_rst_n};
      r_inc_prev     <= r_inc_sync[1];
    end
  end

  assign w_sel_rst_n = r_sel_rst_sync[1];
  assign w_ena       = r_ena_sync[1];
  assign w_ui_rst_n  = r_ui_rst_sync[1];
  assign w_inc_edge  = r_inc_sync[1] & ~r_inc_prev;

  // Any change of selection or loss of enable sends the sequencer home.
  assign w_abort = ~w_ena | ~w_sel_rst_n | w_inc_edge;

  // Design-select counter: cleared by synced select reset, stepped on inc edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_cnt <= 10'd0;
    end else if (!w_sel_rst_n) begin
      r_sel_cnt <= 10'd0;
    end else if (w_inc_edge) begin
      r_sel_cnt <= r_sel_cnt + 10'd1;
    end else begin
      r_sel_cnt <= r_sel_cnt;
    end
  end

  // Sequencer state, phase counter and the registered user-clock enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_clk_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clk_en <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_RUN);
    end
  end

  // Next-state logic; abort outranks phase completion, counter reloads on entry
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!w_abort) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_RESET;
          w_cnt_nxt   = RST_LD;
        end else begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      ST_RESET: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_RESET;
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 8'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Module is powered onto the spine in RESET and RUN; user reset released only in RUN.
  assign w_live     = (r_state == ST_RESET) || (r_state == ST_RUN);
  assign w_run      = (r_state == ST_RUN);
  assign w_um_clk   = pad_ui_clk & r_clk_en;
  assign w_um_rst_n = w_run & w_ui_rst_n;
  assign w_usr      = w_live ? {pad_uio_in, pad_ui_in, w_um_rst_n, w_um_clk}
                             : {(N_IO+N_I){1'b0}};

  assign spine.spine_iw = {1'b0, w_usr, r_sel_cnt, w_live, 1'b0};

  // Return path is only trusted while the selected module is running.
  assign w_ret = w_run ? spine.spine_ow[24:1] : 24'd0;

  // Guard wires on the outward bundle carry nothing.
  assign w_unused_ow_guards = spine.spine_ow[25] ^ spine.spine_ow[0];

`ifdef TT_SPINE_CTRL_OUT_REG_EN
  logic [23:0] r_ret;

  // Registered return path: pads lag spine_ow by one clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret <= 24'd0;
    end else begin
      r_ret <= w_ret;
    end
  end

  assign pad_uo_out  = r_ret[7:0];
  assign pad_uio_out = r_ret[15:8];
  assign pad_uio_oe  = r_ret[23:16];
`else
  assign pad_uo_out  = w_ret[7:0];
  assign pad_uio_out = w_ret[15:8];
  assign pad_uio_oe  = w_ret[23:16];
`endif

  assign dbg_sel   = r_sel_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tt_spine_ctrl.sv
// tb_tt_spine_ctrl: randomized scoreboard bench for tt_spine_ctrl.
// A reference model tracks the sequencer as "cycles since leaving idle" and
// pushes one expected snapshot per clock; a monitor pops and compares on the
// falling edge.
module tb_tt_spine_ctrl;
  localparam int S = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ctrl_sel_rst_n = 1'b0;
  logic       ctrl_sel_inc = 1'b0;
  logic       ctrl_ena = 1'b0;
  logic       pad_ui_clk = 1'b0;
  logic       pad_ui_rst_n = 1'b0;
  logic [7:0] pad_ui_in = 8'd0;
  logic [7:0] pad_uio_in = 8'd0;
  logic [7:0] pad_uo_out;
  logic [7:0] pad_uio_out;
  logic [7:0] pad_uio_oe;
  logic [9:0] dbg_sel;
  logic [1:0] dbg_state;

  tt_spine_ctrl_if sp ();

  tt_spine_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena),
    .pad_ui_clk     (pad_ui_clk),
    .pad_ui_rst_n   (pad_ui_rst_n),
    .pad_ui_in      (pad_ui_in),
    .pad_uio_in     (pad_uio_in),
    .pad_uo_out     (pad_uo_out),
    .pad_uio_out    (pad_uio_out),
    .pad_uio_oe     (pad_uio_oe),
    .spine          (sp.master),
    .dbg_sel        (dbg_sel),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        phase;     // 0 idle, 1 settle, 2 reset, 3 run
    int        sel;
    bit        um_rst_n;
    bit [23:0] ret;       // registered-return expectation
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: pad sample history (index 0 = newest sample).
  int        age = -1;     // -1 idle, else cycles since leaving idle
  int        msel = 0;
  bit        h_sr[3] = '{0, 0, 0};
  bit        h_inc[3] = '{0, 0, 0};
  bit        h_ena[3] = '{0, 0, 0};
  bit        h_ur[3] = '{0, 0, 0};
  bit [23:0] m_ret = 24'd0;
  bit        m_sr, m_ena, m_edge, m_abort;
  int        m_ph_before;
  exp_t      m_e;
  exp_t      mon_e;

  function automatic int phase_of(int a);
    if (a < 0) return 0;
    if (a <= S) return 1;
    if (a <= S + R) return 2;
    return 3;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: advances once per clock and queues the expected outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age = -1;
      msel = 0;
      m_ret = 24'd0;
      for (int i = 0; i < 3; i++) begin
        h_sr[i] = 1'b0; h_inc[i] = 1'b0; h_ena[i] = 1'b0; h_ur[i] = 1'b0;
      end
    end else begin
      m_ph_before = phase_of(age);
      // A pad level becomes visible two clocks after it is first sampled.
      m_sr   = h_sr[1];
      m_ena  = h_ena[1];
      m_edge = h_inc[1] && !h_inc[2];
      if (!m_sr) msel = 0;
      else if (m_edge) msel = (msel + 1) % 1024;
      m_abort = !m_ena || !m_sr || m_edge;
      if (m_abort) age = -1;
      else if (age < 0) age = 1;
      else if (age < 1000) age = age + 1;
      m_ret = (m_ph_before == 3) ? sp.spine_ow[24:1] : 24'd0;
      for (int i = 2; i > 0; i--) begin
        h_sr[i] = h_sr[i-1]; h_inc[i] = h_inc[i-1];
        h_ena[i] = h_ena[i-1]; h_ur[i] = h_ur[i-1];
      end
      h_sr[0] = ctrl_sel_rst_n; h_inc[0] = ctrl_sel_inc;
      h_ena[0] = ctrl_ena; h_ur[0] = pad_ui_rst_n;
      m_e.phase    = phase_of(age);
      m_e.sel      = msel;
      m_e.um_rst_n = (m_e.phase == 3) && h_ur[1];
      m_e.ret      = m_ret;
      q.push_back(m_e);
    end
  end

  // Monitor: compares DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    logic        live;
    logic [17:0] usr;
    logic [30:0] exp_iw;
    logic [23:0] exp_ret;
    if (!rst_n) begin
      q.delete();
      chk("rst_spine_iw", 64'(sp.spine_iw), 64'd0);
      chk("rst_pads", 64'({pad_uio_oe, pad_uio_out, pad_uo_out}), 64'd0);
      chk("rst_sel", 64'(dbg_sel), 64'd0);
    end else if (q.size() == 0) begin
      chk("scoreboard_empty", 64'(q.size()), 64'd1);
    end else begin
      mon_e = q.pop_front();
      live = (mon_e.phase >= 2);
      usr = live ? {pad_uio_in, pad_ui_in, mon_e.um_rst_n, pad_ui_clk} : 18'd0;
      exp_iw = {1'b0, usr, 10'(mon_e.sel), live, 1'b0};
`ifdef TT_SPINE_CTRL_OUT_REG_EN
      exp_ret = mon_e.ret;
`else
      exp_ret = (mon_e.phase == 3) ? sp.spine_ow[24:1] : 24'd0;
`endif
      chk("state", 64'(dbg_state), 64'(mon_e.phase));
      chk("sel", 64'(dbg_sel), 64'(mon_e.sel));
      chk("spine_iw", 64'(sp.spine_iw), 64'(exp_iw));
      chk("uo_out", 64'(pad_uo_out), 64'(exp_ret[7:0]));
      chk("uio_out", 64'(pad_uio_out), 64'(exp_ret[15:8]));
      chk("uio_oe", 64'(pad_uio_oe), 64'(exp_ret[23:16]));
    end
  end

  // Background data stimulus: user inputs, user clock/reset and return bundle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      pad_ui_in    = 8'($urandom);
      pad_uio_in   = 8'($urandom);
      pad_ui_clk   = 1'($urandom);
      pad_ui_rst_n = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) sp.spine_ow = {1'b1, 24'hA53CF0, 1'b1};
      else sp.spine_ow = 26'($urandom);
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic inc_pulse();
    ctrl_sel_inc = 1'b1;
    cyc(1);
    ctrl_sel_inc = 1'b0;
    cyc(1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1);
  endtask

  // Control stimulus: directed scenarios followed by a randomized phase
  initial begin
    sp.spine_ow = 26'd0;
    ctrl_sel_rst_n = 1'b1;
    cyc(4);
    release_reset();

    // Five increments then enable: settle, reset, run.
    cyc(3);
    for (int i = 0; i < 5; i++) inc_pulse();
    ctrl_ena = 1'b1;
    cyc(30);

    // Select reset pulse while running with sel = 37.
    ctrl_ena = 1'b0;
    ctrl_sel_rst_n = 1'b0;
    cyc(3);
    ctrl_sel_rst_n = 1'b1;
    cyc(3);
    for (int i = 0; i < 37; i++) inc_pulse();
    ctrl_ena = 1'b1;
    cyc(25);
    ctrl_sel_rst_n = 1'b0;
    cyc(2);
    ctrl_sel_rst_n = 1'b1;
    cyc(6);

    // Wrap 1023 -> 0, then an increment during RUN re-sequences.
    ctrl_ena = 1'b0;
    ctrl_sel_rst_n = 1'b0;
    cyc(3);
    ctrl_sel_rst_n = 1'b1;
    cyc(3);
    for (int i = 0; i < 1024; i++) inc_pulse();
    ctrl_ena = 1'b1;
    cyc(25);
    inc_pulse();
    cyc(25);

    // Drop enable after a sweep of delays, including the last settle cycle.
    for (int d = 0; d < 14; d++) begin
      ctrl_ena = 1'b0;
      cyc(5);
      ctrl_ena = 1'b1;
      cyc(d);
      ctrl_ena = 1'b0;
      cyc(6);
    end

    // Randomized control activity.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) ctrl_ena = ~ctrl_ena;
      ctrl_sel_rst_n = ($urandom_range(0, 59) != 0);
      ctrl_sel_inc   = ($urandom_range(0, 29) == 0);
      cyc(1);
    end

    // Controller reset in the middle of a run.
    ctrl_sel_inc = 1'b0;
    ctrl_sel_rst_n = 1'b1;
    ctrl_ena = 1'b1;
    cyc(25);
    rst_n = 1'b0;
    cyc(3);
    release_reset();
    cyc(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
